// File: rtl/pulse_stretcher_pkg.sv
// Shared state encoding and sizing helper for the pulse stretcher.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ESPERE = 2'b00,
        ESTIRE = 2'b01,
        PAUSA  = 2'b11
    } state_t;

    // Hold counter must reach both LEN-1 and GAP-1; never narrower than one bit.
    function automatic int hold_w(input int len, input int gap);
        int m;
        m = (len > gap) ? len : gap;
        return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pulse_stretcher_hold_timer.sv
// Loadable down-counter with zero flag; load wins over decrement.
module hold_timer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle pulses into a LEN-cycle level followed by a GAP-cycle lockout.
// All outputs are registered; no combinational path from i_pulso to any output.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int LEN    = 8,
    parameter int GAP    = 2,
    parameter bit RETRIG = 1'b0,
    parameter int CNT_W  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pulso,
    output logic             o_nivel,
    output logic             o_ocupado,
    output logic             o_perdido,
    output logic [CNT_W-1:0] o_aceptados
);

    localparam int HW = hold_w(LEN, GAP);
    localparam logic [HW-1:0] LEN_M1 = HW'(LEN - 1);
    localparam logic [HW-1:0] GAP_M1 = HW'((GAP > 0) ? (GAP - 1) : 0);

    state_t           r_state;
    logic             r_nivel;
    logic             r_ocupado;
    logic             r_perdido;
    logic [CNT_W-1:0] r_aceptados;

    state_t           w_next;
    logic             w_load;
    logic [HW-1:0]    w_load_val;
    logic             w_dec;
    logic             w_accept;
    logic             w_drop;
    logic             w_zero;

    hold_timer #(.W(HW)) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = LEN_M1;
        w_dec      = 1'b0;
        w_accept   = 1'b0;
        w_drop     = 1'b0;
        case (r_state)
            ESPERE: begin
                if (i_pulso) begin
                    w_next   = ESTIRE;
                    w_load   = 1'b1;
                    w_accept = 1'b1;
                end
            end
            ESTIRE: begin
                // A retrigger reload takes priority over expiry, so the level never glitches low.
                if (i_pulso && RETRIG) begin
                    w_load   = 1'b1;
                    w_accept = 1'b1;
                end else begin
                    w_drop = i_pulso;
                    if (w_zero) begin
                        if (GAP > 0) begin
                            w_next     = PAUSA;
                            w_load     = 1'b1;
                            w_load_val = GAP_M1;
                        end else begin
                            w_next = ESPERE;
                        end
                    end else begin
                        w_dec = 1'b1;
                    end
                end
            end
            PAUSA: begin
                w_drop = i_pulso;
                if (w_zero) begin
                    w_next = ESPERE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_next = ESPERE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ESPERE;
            r_nivel     <= 1'b0;
            r_ocupado   <= 1'b0;
            r_perdido   <= 1'b0;
            r_aceptados <= '0;
        end else begin
            r_state   <= w_next;
            r_nivel   <= (w_next == ESTIRE);
            r_ocupado <= (w_next != ESPERE);
            r_perdido <= w_drop;
            if (w_accept) begin
                r_aceptados <= r_aceptados + CNT_W'(1);
            end
        end
    end

    assign o_nivel     = r_nivel;
    assign o_ocupado   = r_ocupado;
    assign o_perdido   = r_perdido;
    assign o_aceptados = r_aceptados;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench: four parameterisations driven edge by edge against hand-derived expectations.
module tb_pulse_stretcher;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pa = 1'b0, pb = 1'b0, pc = 1'b0, pd = 1'b0;

    logic       a_niv, a_ocu, a_per;
    logic [7:0] a_acc;
    logic       b_niv, b_ocu, b_per;
    logic [7:0] b_acc;
    logic       c_niv, c_ocu, c_per;
    logic [7:0] c_acc;
    logic       d_niv, d_ocu, d_per;
    logic [1:0] d_acc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pulse_stretcher #(.LEN(8), .GAP(2), .RETRIG(1'b0), .CNT_W(8)) u_a (
        .i_clk(clk), .i_rst(rst), .i_pulso(pa),
        .o_nivel(a_niv), .o_ocupado(a_ocu), .o_perdido(a_per), .o_aceptados(a_acc));
    pulse_stretcher #(.LEN(4), .GAP(0), .RETRIG(1'b1), .CNT_W(8)) u_b (
        .i_clk(clk), .i_rst(rst), .i_pulso(pb),
        .o_nivel(b_niv), .o_ocupado(b_ocu), .o_perdido(b_per), .o_aceptados(b_acc));
    pulse_stretcher #(.LEN(1), .GAP(0), .RETRIG(1'b0), .CNT_W(8)) u_c (
        .i_clk(clk), .i_rst(rst), .i_pulso(pc),
        .o_nivel(c_niv), .o_ocupado(c_ocu), .o_perdido(c_per), .o_aceptados(c_acc));
    pulse_stretcher #(.LEN(2), .GAP(1), .RETRIG(1'b0), .CNT_W(2)) u_d (
        .i_clk(clk), .i_rst(rst), .i_pulso(pd),
        .o_nivel(d_niv), .o_ocupado(d_ocu), .o_perdido(d_per), .o_aceptados(d_acc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pa = 1'b0; pb = 1'b0; pc = 1'b0; pd = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int c;

        // Reset state on every instance.
        do_reset();
        chk("rst a_nivel", a_niv, 0);
        chk("rst a_ocupado", a_ocu, 0);
        chk("rst a_perdido", a_per, 0);
        chk("rst a_aceptados", a_acc, 0);
        chk("rst b_nivel", b_niv, 0);
        chk("rst c_aceptados", c_acc, 0);
        chk("rst d_aceptados", d_acc, 0);

        // LEN=8 GAP=2: single pulse at edge 10; cycle c follows edge c-1.
        for (int e = 1; e <= 22; e++) begin
            pa = (e == 10);
            step();
            c = e + 1;
            chk($sformatf("t1 nivel c%0d", c), a_niv, (c >= 11 && c <= 18));
            chk($sformatf("t1 ocupado c%0d", c), a_ocu, (c >= 11 && c <= 20));
            chk($sformatf("t1 perdido c%0d", c), a_per, 0);
            chk($sformatf("t1 aceptados c%0d", c), a_acc, (c >= 11) ? 1 : 0);
        end

        // Same, extra pulses at 14 (in stretch) and 19 (in gap) are both dropped.
        do_reset();
        for (int e = 1; e <= 22; e++) begin
            pa = (e == 10 || e == 14 || e == 19);
            step();
            c = e + 1;
            chk($sformatf("t2 nivel c%0d", c), a_niv, (c >= 11 && c <= 18));
            chk($sformatf("t2 ocupado c%0d", c), a_ocu, (c >= 11 && c <= 20));
            chk($sformatf("t2 perdido c%0d", c), a_per, (c == 15 || c == 20));
            chk($sformatf("t2 aceptados c%0d", c), a_acc, (c >= 11) ? 1 : 0);
        end

        // RETRIG=1 LEN=4 GAP=0: pulses at 5 and 7 give one unbroken level 6..11.
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            pb = (e == 5 || e == 7);
            step();
            c = e + 1;
            chk($sformatf("t3 nivel c%0d", c), b_niv, (c >= 6 && c <= 11));
            chk($sformatf("t3 ocupado c%0d", c), b_ocu, (c >= 6 && c <= 11));
            chk($sformatf("t3 perdido c%0d", c), b_per, 0);
            chk($sformatf("t3 aceptados c%0d", c), b_acc, (c >= 8) ? 2 : ((c >= 6) ? 1 : 0));
        end

        // LEN=1 GAP=0: pulso held for edges 1..6, every other event accepted.
        do_reset();
        for (int e = 1; e <= 9; e++) begin
            pc = (e <= 6);
            step();
            c = e + 1;
            chk($sformatf("t4 nivel c%0d", c), c_niv, (c <= 7 && (c % 2) == 0));
            chk($sformatf("t4 perdido c%0d", c), c_per, (c <= 7 && (c % 2) == 1));
            chk($sformatf("t4 aceptados c%0d", c), c_acc, (c <= 7) ? (c / 2) : 3);
        end

        // Pulse at 3, reset together with a pulse at 6: everything clear from cycle 7.
        do_reset();
        for (int e = 1; e <= 9; e++) begin
            pa  = (e == 3 || e == 6);
            rst = (e == 6);
            step();
            c = e + 1;
            chk($sformatf("t5 nivel c%0d", c), a_niv, (c >= 4 && c <= 6));
            chk($sformatf("t5 ocupado c%0d", c), a_ocu, (c >= 4 && c <= 6));
            chk($sformatf("t5 perdido c%0d", c), a_per, 0);
            chk($sformatf("t5 aceptados c%0d", c), a_acc, (c >= 4 && c <= 6) ? 1 : 0);
        end
        rst = 1'b0;

        // CNT_W=2: five well-spaced pulses, counter reads 1,2,3,0,1.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pd = 1'b1;
            step();
            pd = 1'b0;
            chk($sformatf("t6 aceptados #%0d", i + 1), d_acc, (i + 1) % 4);
            chk($sformatf("t6 nivel #%0d", i + 1), d_niv, 1);
            for (int k = 0; k < 5; k++) step();
            chk($sformatf("t6 idle #%0d", i + 1), d_ocu, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
